// File: rtl/dac_stream_ctrl.sv
// dac_stream_ctrl: buffers DAC codes and releases one per sample period as binary + thermometer data.
// Optional macro DAC_DEM_EN enables rotating data-weighted-averaging of the thermometer elements.
module dac_stream_ctrl #(
    parameter int CODE_W     = 10,
    parameter int BIN_W      = 7,
    parameter int THERM_W    = 17,
    parameter int FIFO_DEPTH = 8,
    parameter int SETTLE_CYC = 16
) (
    input  logic               clkin,
    input  logic               rstb,
    input  logic               en,
    input  logic [7:0]         div,
    input  logic               s_valid,
    input  logic [CODE_W-1:0]  s_code,
    output logic               s_ready,
    output logic               pdb,
    output logic [0:BIN_W-1]   datainbin,
    output logic [0:BIN_W-1]   datainbinb,
    output logic [0:THERM_W-1] dataintherm,
    output logic [0:THERM_W-1] datainthermb,
    output logic               running,
    output logic [7:0]         underflow_cnt
);

    localparam int MSB_W = CODE_W - BIN_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {ST_OFF, ST_SETTLE, ST_RUN, ST_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [7:0]         strb_q, strb_d;
    logic [7:0]         div_q, div_d;
    logic [7:0]         unf_q, unf_d;
    logic               running_q, running_d;
    logic [CODE_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [0:BIN_W-1]   bin_q, bin_d, binb_q, binb_d;
    logic [0:THERM_W-1] therm_q, therm_d, thermb_q, thermb_d;

    logic               active, strobe, settle_done, empty, full;
    logic               push, pop, flush, start;
    logic [CODE_W-1:0]  head;
    logic [MSB_W-1:0]   msb_n;
    logic [0:BIN_W-1]   bin_dec;
    logic [0:THERM_W-1] therm_dec;

    assign active      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign strobe      = active && (strb_q == div_q);
    assign settle_done = (settle_q == SET_W'(SETTLE_CYC - 1));
    assign empty       = (count_q == '0);
    assign full        = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop         = strobe && !empty;
    assign push        = s_valid && s_ready;
    assign start       = (state_q == ST_OFF) && en;
    assign flush       = (state_d == ST_OFF);
    assign head        = mem_q[rd_q];
    assign msb_n       = head[CODE_W-1:BIN_W];

    always_ff @(posedge clkin or negedge rstb) begin
        if (!rstb) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF: begin
                if (en) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!en) state_d = ST_OFF;
                else if (settle_done) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!en) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (strobe && empty) state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase
    end

    // While full, a slot is offered only in a cycle where the head is popped.
    always_comb begin
        pdb     = 1'b1;
        s_ready = 1'b0;
        case (state_q)
            ST_OFF:    pdb = 1'b0;
            ST_SETTLE: s_ready = !full;
            ST_RUN:    s_ready = !full || pop;
            default:   ;
        endcase
    end

`ifdef DAC_DEM_EN
    localparam int P_W = $clog2(THERM_W);

    logic [P_W-1:0] p_q, p_d;
    logic [P_W:0]   p_sum;

    assign p_sum = {1'b0, p_q} + (P_W+1)'(msb_n);

    always_comb begin
        p_d = p_q;
        if (flush) begin
            p_d = '0;
        end else if (pop) begin
            p_d = (p_sum >= (P_W+1)'(THERM_W)) ? P_W'(p_sum - (P_W+1)'(THERM_W)) : P_W'(p_sum);
        end
    end

    always_ff @(posedge clkin or negedge rstb) begin
        if (!rstb) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end
`endif

    // Element i is lit when its distance past the rotation pointer is below the MSB count.
    always_comb begin
        int off;
        off       = 0;
        bin_dec   = '0;
        therm_dec = '0;
        for (int i = 0; i < BIN_W; i++) begin
            bin_dec[i] = head[i];
        end
        for (int i = 0; i < THERM_W; i++) begin
`ifdef DAC_DEM_EN
            off = (i >= int'(p_q)) ? i - int'(p_q) : i + THERM_W - int'(p_q);
`else
            off = i;
`endif
            therm_dec[i] = (off < int'(msb_n));
        end
    end

    always_comb begin
        settle_d  = (state_q == ST_SETTLE) ? settle_q + SET_W'(1) : '0;
        strb_d    = '0;
        if (active) strb_d = strobe ? '0 : strb_q + 8'd1;
        div_d     = start ? div : div_q;
        running_d = (state_d == ST_RUN);

        unf_d = unf_q;
        if (start) begin
            unf_d = '0;
        end else if ((state_q == ST_RUN) && strobe && empty && (unf_q != 8'hFF)) begin
            unf_d = unf_q + 8'd1;
        end

        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push) wr_d = wr_q + PTR_W'(1);
            if (pop)  rd_d = rd_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end

        bin_d    = bin_q;
        binb_d   = binb_q;
        therm_d  = therm_q;
        thermb_d = thermb_q;
        if (flush) begin
            bin_d    = '0;
            binb_d   = '1;
            therm_d  = '0;
            thermb_d = '1;
        end else if (pop) begin
            bin_d    = bin_dec;
            binb_d   = ~bin_dec;
            therm_d  = therm_dec;
            thermb_d = ~therm_dec;
        end
    end

    always_ff @(posedge clkin or negedge rstb) begin
        if (!rstb) begin
            settle_q  <= '0;
            strb_q    <= '0;
            div_q     <= '0;
            unf_q     <= '0;
            running_q <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            bin_q     <= '0;
            binb_q    <= '1;
            therm_q   <= '0;
            thermb_q  <= '1;
        end else begin
            settle_q  <= settle_d;
            strb_q    <= strb_d;
            div_q     <= div_d;
            unf_q     <= unf_d;
            running_q <= running_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            count_q   <= count_d;
            bin_q     <= bin_d;
            binb_q    <= binb_d;
            therm_q   <= therm_d;
            thermb_q  <= thermb_d;
        end
    end

    always_ff @(posedge clkin) begin
        if (push) mem_q[wr_q] <= s_code;
    end

    assign datainbin     = bin_q;
    assign datainbinb    = binb_q;
    assign dataintherm   = therm_q;
    assign datainthermb  = thermb_q;
    assign running       = running_q;
    assign underflow_cnt = unf_q;

endmodule

// File: tb/tb_dac_stream_ctrl.sv
// tb_dac_stream_ctrl: directed bench for dac_stream_ctrl covering power-up, streaming, drain,
// backpressure, asynchronous reset and underflow saturation, in both DAC_DEM_EN builds.
module tb_dac_stream_ctrl;

    logic        clkin = 1'b0;
    logic        rstb;
    logic        en;
    logic [7:0]  div;
    logic        s_valid;
    logic [9:0]  s_code;
    logic        s_ready;
    logic        pdb;
    logic [0:6]  datainbin;
    logic [0:6]  datainbinb;
    logic [0:16] dataintherm;
    logic [0:16] datainthermb;
    logic        running;
    logic [7:0]  underflow_cnt;

    int vectors     = 0;
    int miscompares = 0;

`ifdef DAC_DEM_EN
    localparam logic [16:0] S2T1 = 17'h0007F, S2T2 = 17'h03F80, S2T3 = 17'h1C00F;
    localparam logic [16:0] S2T4 = 17'h00030, S2T5 = 17'h007C0;
    localparam logic [16:0] S3T1 = 17'h00001, S3T2 = 17'h00006, S3T3 = 17'h00038;
    localparam logic [16:0] S4TA = 17'h00001, S4TB = 17'h000FE;
`else
    localparam logic [16:0] S2T1 = 17'h0007F, S2T2 = 17'h0007F, S2T3 = 17'h0007F;
    localparam logic [16:0] S2T4 = 17'h00003, S2T5 = 17'h0001F;
    localparam logic [16:0] S3T1 = 17'h00001, S3T2 = 17'h00003, S3T3 = 17'h00007;
    localparam logic [16:0] S4TA = 17'h00001, S4TB = 17'h0007F;
`endif

    dac_stream_ctrl dut (
        .clkin         (clkin),
        .rstb          (rstb),
        .en            (en),
        .div           (div),
        .s_valid       (s_valid),
        .s_code        (s_code),
        .s_ready       (s_ready),
        .pdb           (pdb),
        .datainbin     (datainbin),
        .datainbinb    (datainbinb),
        .dataintherm   (dataintherm),
        .datainthermb  (datainthermb),
        .running       (running),
        .underflow_cnt (underflow_cnt)
    );

    always #5 clkin = ~clkin;

    task automatic step(input int n);
        repeat (n) @(negedge clkin);
    endtask

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Buses are [0:N] with element i at index i; repack so bit i of the value is element i.
    task automatic checkOutput(input string tag, input logic [6:0] expBin, input logic [16:0] expTherm);
        logic [6:0]  b, bbar, nb;
        logic [16:0] t, tbar, nt;
        for (int i = 0; i < 7; i++) begin
            b[i]    = datainbin[i];
            bbar[i] = datainbinb[i];
        end
        for (int i = 0; i < 17; i++) begin
            t[i]    = dataintherm[i];
            tbar[i] = datainthermb[i];
        end
        nb = ~expBin;
        nt = ~expTherm;
        checkEq({tag, ".bin"},    32'(b),    32'(expBin));
        checkEq({tag, ".binb"},   32'(bbar), 32'(nb));
        checkEq({tag, ".therm"},  32'(t),    32'(expTherm));
        checkEq({tag, ".thermb"}, 32'(tbar), 32'(nt));
    endtask

    task automatic applyStimulus(input logic [9:0] code);
        s_valid = 1'b1;
        s_code  = code;
        @(negedge clkin);
        s_valid = 1'b0;
    endtask

    task automatic powerUp(input logic [7:0] d);
        div = d;
        en  = 1'b1;
        @(negedge clkin);
    endtask

    initial begin
        rstb = 1'b0; en = 1'b0; div = 8'd0; s_valid = 1'b0; s_code = '0;
        step(2);
        checkEq("rst.pdb", 32'(pdb), 32'd0);
        checkEq("rst.s_ready", 32'(s_ready), 32'd0);
        checkEq("rst.running", 32'(running), 32'd0);
        checkEq("rst.underflow", 32'(underflow_cnt), 32'd0);
        checkOutput("rst", 7'h00, 17'h0);
        rstb = 1'b1;
        step(2);
        checkEq("idle.pdb", 32'(pdb), 32'd0);
        checkEq("idle.s_ready", 32'(s_ready), 32'd0);
        checkOutput("idle", 7'h00, 17'h0);

        // Session 1: power-up timing, div=3 stream, underflow, drain from empty
        powerUp(8'd3);
        checkEq("s1.pdb_up", 32'(pdb), 32'd1);
        checkEq("s1.s_ready", 32'(s_ready), 32'd1);
        checkEq("s1.running_early", 32'(running), 32'd0);
        applyStimulus(10'h000);
        applyStimulus(10'h07F);
        applyStimulus(10'h3FF);
        step(12);
        checkEq("s1.running_n16", 32'(running), 32'd0);
        step(1);
        checkEq("s1.running_n17", 32'(running), 32'd1);
        step(3);
        checkOutput("s1.before_strobe", 7'h00, 17'h0);
        step(5);
        checkOutput("s1.code07f", 7'h7F, 17'h0);
        step(3);
        checkOutput("s1.hold07f", 7'h7F, 17'h0);
        step(1);
        checkOutput("s1.code3ff", 7'h7F, 17'h0007F);
        checkEq("s1.underflow0", 32'(underflow_cnt), 32'd0);
        step(4);
        checkEq("s1.underflow1", 32'(underflow_cnt), 32'd1);
        checkOutput("s1.hold3ff", 7'h7F, 17'h0007F);
        step(4);
        checkEq("s1.underflow2", 32'(underflow_cnt), 32'd2);
        en = 1'b0;
        step(1);
        checkEq("s1.running_drain", 32'(running), 32'd0);
        checkEq("s1.s_ready_drain", 32'(s_ready), 32'd0);
        step(2);
        checkEq("s1.pdb_drain", 32'(pdb), 32'd1);
        checkOutput("s1.drain_hold", 7'h7F, 17'h0007F);
        step(1);
        checkEq("s1.pdb_off", 32'(pdb), 32'd0);
        checkOutput("s1.zero", 7'h00, 17'h0);
        checkEq("s1.underflow_final", 32'(underflow_cnt), 32'd2);

        // Session 2: five queued codes drained with div=1, including the rotation sequence
        powerUp(8'd1);
        checkEq("s2.underflow_clear", 32'(underflow_cnt), 32'd0);
        applyStimulus(10'h380);
        applyStimulus(10'h380);
        applyStimulus(10'h380);
        applyStimulus(10'h155);
        applyStimulus(10'h2AA);
        step(11);
        checkEq("s2.running", 32'(running), 32'd1);
        en = 1'b0;
        step(1);
        checkEq("s2.running_drop", 32'(running), 32'd0);
        checkEq("s2.s_ready_drain", 32'(s_ready), 32'd0);
        step(1);
        checkOutput("s2.c1", 7'h00, S2T1);
        step(2);
        checkOutput("s2.c2", 7'h00, S2T2);
        step(2);
        checkOutput("s2.c3", 7'h00, S2T3);
        step(2);
        checkOutput("s2.c4", 7'h55, S2T4);
        step(2);
        checkOutput("s2.c5", 7'h2A, S2T5);
        checkEq("s2.pdb_c5", 32'(pdb), 32'd1);
        step(1);
        checkOutput("s2.hold_c5", 7'h2A, S2T5);
        step(1);
        checkOutput("s2.zero", 7'h00, 17'h0);
        checkEq("s2.pdb_off", 32'(pdb), 32'd0);

        // Session 3: fill to 8, push into a popping full FIFO, then asynchronous reset mid-run
        powerUp(8'd2);
        applyStimulus(10'h081);
        applyStimulus(10'h102);
        applyStimulus(10'h183);
        applyStimulus(10'h204);
        applyStimulus(10'h285);
        applyStimulus(10'h306);
        applyStimulus(10'h387);
        applyStimulus(10'h008);
        checkEq("s3.full_s_ready", 32'(s_ready), 32'd0);
        s_valid = 1'b1;
        s_code  = 10'h3C9;
        step(8);
        checkEq("s3.running", 32'(running), 32'd1);
        step(1);
        checkEq("s3.s_ready_nopop", 32'(s_ready), 32'd0);
        step(1);
        checkEq("s3.s_ready_pop", 32'(s_ready), 32'd1);
        step(1);
        checkEq("s3.s_ready_refull", 32'(s_ready), 32'd0);
        checkOutput("s3.c1", 7'h01, S3T1);
        s_valid = 1'b0;
        step(3);
        checkOutput("s3.c2", 7'h02, S3T2);
        step(3);
        checkOutput("s3.c3", 7'h03, S3T3);
        #2;
        rstb = 1'b0;
        en   = 1'b0;
        #1;
        checkOutput("s3.async_rst", 7'h00, 17'h0);
        checkEq("s3.rst_running", 32'(running), 32'd0);
        checkEq("s3.rst_pdb", 32'(pdb), 32'd0);
        checkEq("s3.rst_s_ready", 32'(s_ready), 32'd0);
        step(1);
        rstb = 1'b1;
        step(1);

        // Session 4: two codes at div=0, then underflow counting to saturation
        powerUp(8'd0);
        checkEq("s4.s_ready_flushed", 32'(s_ready), 32'd1);
        applyStimulus(10'h0AA);
        applyStimulus(10'h3D5);
        step(14);
        checkEq("s4.running", 32'(running), 32'd1);
        step(1);
        checkOutput("s4.cA", 7'h2A, S4TA);
        step(1);
        checkOutput("s4.cB", 7'h55, S4TB);
        checkEq("s4.underflow0", 32'(underflow_cnt), 32'd0);
        step(1);
        checkEq("s4.underflow1", 32'(underflow_cnt), 32'd1);
        step(2);
        checkEq("s4.underflow3", 32'(underflow_cnt), 32'd3);
        step(251);
        checkEq("s4.underflow254", 32'(underflow_cnt), 32'd254);
        step(1);
        checkEq("s4.underflow255", 32'(underflow_cnt), 32'd255);
        step(48);
        checkEq("s4.underflow_sat", 32'(underflow_cnt), 32'd255);
        checkOutput("s4.hold_cB", 7'h55, S4TB);
        en = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
